key_flag_gen: RTL

KEY_FLAG_GEN -- requirements
Module: key_flag_gen

---
 rtl/key_pkg.sv | 18 +
 rtl/key_debounce.sv | 123 ++++++++++++
 rtl/key_flag_gen.sv | 42 ++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared types and default timing for the push-button flag generator.
// Timing defaults assume a 25 MHz clock.
package key_pkg;

   localparam int CNT_W = 32;

   localparam int DEF_T_DEBOUNCE     = 500_000;
   localparam int DEF_T_REPEAT_DELAY = 25_000_000;
   localparam int DEF_T_REPEAT       = 5_000_000;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_FILT = 2'd1,
      HELD       = 2'd2,
      REL_FILT   = 2'd3
   } key_state_t;

endpackage

// File: rtl/key_debounce.sv
// One push-button channel: 2-flop synchronizer, press/release debounce FSM
// and an optional auto-repeat generator producing one-cycle flag pulses.
module key_debounce
   import key_pkg::*;
#(
   parameter int T_DEBOUNCE     = DEF_T_DEBOUNCE,
   parameter int T_REPEAT_DELAY = DEF_T_REPEAT_DELAY,
   parameter int T_REPEAT       = DEF_T_REPEAT,
   parameter bit REPEAT_EN      = 1'b1
)(
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic flag
);

   localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(T_DEBOUNCE - 1);
   localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(T_REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] REP_LAST   = CNT_W'(T_REPEAT - 1);

   logic [1:0]       sync;
   logic             key;
   key_state_t       state, state_nxt;
   logic [CNT_W-1:0] filt_cnt, filt_nxt;
   logic [CNT_W-1:0] rep_cnt, rep_nxt;
   logic [CNT_W-1:0] rep_last;
   logic             armed, armed_nxt;
   logic             flag_nxt;

   assign key = sync[1];

   // Synchronizer flops idle at 1 so reset looks like a released key.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= 2'b11;
      end else begin
         sync <= {sync[0], key_n};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         filt_cnt <= '0;
         rep_cnt  <= '0;
         armed    <= 1'b0;
         flag     <= 1'b0;
      end else begin
         state    <= state_nxt;
         filt_cnt <= filt_nxt;
         rep_cnt  <= rep_nxt;
         armed    <= armed_nxt;
         flag     <= flag_nxt;
      end
   end

   // The first repeat waits the long delay; once it fires, the short period applies.
   assign rep_last = armed ? REP_LAST : DELAY_LAST;

   always_comb begin
      state_nxt = state;
      filt_nxt  = filt_cnt;
      rep_nxt   = rep_cnt;
      armed_nxt = armed;
      flag_nxt  = 1'b0;
      unique case (state)
         IDLE: begin
            filt_nxt  = '0;
            rep_nxt   = '0;
            armed_nxt = 1'b0;
            if (!key) begin
               state_nxt = PRESS_FILT;
            end
         end
         PRESS_FILT: begin
            if (key) begin
               state_nxt = IDLE;
               filt_nxt  = '0;
            end else if (filt_cnt == DEB_LAST) begin
               state_nxt = HELD;
               filt_nxt  = '0;
               rep_nxt   = '0;
               armed_nxt = 1'b0;
               flag_nxt  = 1'b1;
            end else begin
               filt_nxt = filt_cnt + 1'b1;
            end
         end
         HELD: begin
            if (key) begin
               state_nxt = REL_FILT;
               filt_nxt  = '0;
            end else if (REPEAT_EN) begin
               if (rep_cnt == rep_last) begin
                  rep_nxt   = '0;
                  armed_nxt = 1'b1;
                  flag_nxt  = 1'b1;
               end else begin
                  rep_nxt = rep_cnt + 1'b1;
               end
            end
         end
         REL_FILT: begin
            // A low sample here is a release bounce: resume holding, restart the delay.
            if (!key) begin
               state_nxt = HELD;
               filt_nxt  = '0;
               rep_nxt   = '0;
               armed_nxt = 1'b0;
            end else if (filt_cnt == DEB_LAST) begin
               state_nxt = IDLE;
               filt_nxt  = '0;
            end else begin
               filt_nxt = filt_cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: rtl/key_flag_gen.sv
// Two independent debounced push-buttons: "add" with auto-repeat while held,
// "adjust" with a single pulse per press.
module key_flag_gen
   import key_pkg::*;
#(
   parameter int T_DEBOUNCE     = DEF_T_DEBOUNCE,
   parameter int T_REPEAT_DELAY = DEF_T_REPEAT_DELAY,
   parameter int T_REPEAT       = DEF_T_REPEAT
)(
   input  logic clk_25m,
   input  logic rst_n_25m,
   input  logic key_add_n,
   input  logic key_adjust_n,
   output logic flag_add,
   output logic flag_adjust
);

   key_debounce #(
      .T_DEBOUNCE     (T_DEBOUNCE),
      .T_REPEAT_DELAY (T_REPEAT_DELAY),
      .T_REPEAT       (T_REPEAT),
      .REPEAT_EN      (1'b1)
   ) u_add (
      .clk   (clk_25m),
      .rst_n (rst_n_25m),
      .key_n (key_add_n),
      .flag  (flag_add)
   );

   key_debounce #(
      .T_DEBOUNCE     (T_DEBOUNCE),
      .T_REPEAT_DELAY (T_REPEAT_DELAY),
      .T_REPEAT       (T_REPEAT),
      .REPEAT_EN      (1'b0)
   ) u_adjust (
      .clk   (clk_25m),
      .rst_n (rst_n_25m),
      .key_n (key_adjust_n),
      .flag  (flag_adjust)
   );

endmodule
